// File: rtl/product_accumulator.sv
// product_accumulator: sums blocks of multiplier products behind valid/ready.
// Optional saturation via PRODUCT_ACC_SAT_EN (undefined: wrap modulo 2^ACC_W).
module product_accumulator #(
  parameter int ACC_W     = 12,
  parameter int BLOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_product,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] BLEN = 8'(BLOCK_LEN);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic             xfer;
  logic             dlvr;
  logic [ACC_W:0]   sum_w;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [7:0]       cnt_add;
  logic             ovf_add;
  logic             close_x;
  logic             close_f;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign xfer      = in_valid && in_ready;
  assign dlvr      = out_valid && out_ready;

  assign sum_w   = {1'b0, acc} + (ACC_W+1)'(in_product);
  assign carry   = sum_w[ACC_W];
  assign cnt_add = cnt + 8'd1;
  assign ovf_add = ovf | carry;
`ifdef PRODUCT_ACC_SAT_EN
  assign acc_add = carry ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign acc_add = sum_w[ACC_W-1:0];
`endif

  assign close_x = xfer && ((cnt_add == BLEN) || flush);
  assign close_f = !xfer && flush && (state == ACCUM);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (close_x)   state_nxt = DONE;
        else if (xfer) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (close_x || close_f) state_nxt = DONE;
      end
      DONE: begin
        if (dlvr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Running block totals; cleared when the result is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (dlvr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (xfer) begin
      acc <= acc_add;
      cnt <= cnt_add;
      ovf <= ovf_add;
    end
  end

  // Result registers, loaded only when a block closes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (close_x) begin
      out_sum   <= acc_add;
      out_count <= cnt_add;
      out_ovf   <= ovf_add;
    end else if (close_f) begin
      out_sum   <= acc;
      out_count <= cnt;
      out_ovf   <= ovf;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vectors for product_accumulator.
// Covers full block, flush, backpressure, overflow/saturation and reset.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_product;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [11:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  b_product;
  logic        b_valid;
  logic        b_ready;
  logic        b_flush;
  logic [7:0]  b_sum;
  logic [7:0]  b_count;
  logic        b_ovf;
  logic        b_ovalid;
  logic        b_oready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(12), .BLOCK_LEN(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_product(in_product), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  product_accumulator #(.ACC_W(8), .BLOCK_LEN(2)) u_ovf (
    .clk(clk), .rst(rst),
    .in_product(b_product), .in_valid(b_valid), .in_ready(b_ready),
    .flush(b_flush),
    .out_sum(b_sum), .out_count(b_count), .out_ovf(b_ovf),
    .out_valid(b_ovalid), .out_ready(b_oready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] p, input logic f);
    in_product = p;
    in_valid   = 1'b1;
    flush      = f;
    step();
    in_valid   = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_product = '0; in_valid = 0; flush = 0; out_ready = 1;
    b_product = '0; b_valid = 0; b_flush = 0; b_oready = 1;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_sum", 32'(out_sum), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    step();
    rst = 1'b0;
    step();

    // Full block of 4 x 225
    in_product = 8'd225;
    in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_early", 32'(out_valid), 0);
    end
    step();
    in_valid = 1'b0;
    chk("full_valid", 32'(out_valid), 1);
    chk("full_sum", 32'(out_sum), 900);
    chk("full_count", 32'(out_count), 4);
    chk("full_ovf", 32'(out_ovf), 0);
    chk("full_rdy_done", 32'(in_ready), 0);
    step();
    chk("full_idle_v", 32'(out_valid), 0);
    chk("full_idle_r", 32'(in_ready), 1);

    // Flush closing a partial block
    push(8'd10, 1'b0);
    push(8'd20, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 1);
    chk("flush_sum", 32'(out_sum), 30);
    chk("flush_count", 32'(out_count), 2);
    step();
    chk("flush_dlv", 32'(out_valid), 0);

    // Flush in IDLE is ignored
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", 32'(out_valid), 0);
    step();
    chk("flush_idle2", 32'(out_valid), 0);

    // Flush together with a transfer from IDLE
    push(8'd5, 1'b1);
    chk("fx_valid", 32'(out_valid), 1);
    chk("fx_sum", 32'(out_sum), 5);
    chk("fx_count", 32'(out_count), 1);
    step();

    // Backpressure
    out_ready = 1'b0;
    push(8'd1, 1'b0);
    push(8'd2, 1'b0);
    push(8'd3, 1'b0);
    push(8'd4, 1'b0);
    chk("bp_valid", 32'(out_valid), 1);
    in_product = 8'd50;
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_hold_v", 32'(out_valid), 1);
      chk("bp_hold_s", 32'(out_sum), 10);
      chk("bp_hold_c", 32'(out_count), 4);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_dlv", 32'(out_valid), 0);
    push(8'd7, 1'b1);
    chk("bp_next_sum", 32'(out_sum), 7);
    chk("bp_next_cnt", 32'(out_count), 1);
    step();

    // Overflow on the 8-bit, 2-deep instance
    b_product = 8'd200;
    b_valid   = 1'b1;
    step();
    chk("ovf_mid", 32'(b_ovalid), 0);
    b_product = 8'd100;
    step();
    b_valid = 1'b0;
    chk("ovf_valid", 32'(b_ovalid), 1);
`ifdef PRODUCT_ACC_SAT_EN
    chk("ovf_sum", 32'(b_sum), 255);
`else
    chk("ovf_sum", 32'(b_sum), 44);
`endif
    chk("ovf_flag", 32'(b_ovf), 1);
    chk("ovf_count", 32'(b_count), 2);
    step();
    chk("ovf_dlv", 32'(b_ovalid), 0);

    // Reset mid-block discards the partial sum
    push(8'd1, 1'b0);
    push(8'd1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid_valid", 32'(out_valid), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(8'd1, 1'b0);
    chk("rmid_sum", 32'(out_sum), 4);
    chk("rmid_count", 32'(out_count), 4);
    chk("rmid_v", 32'(out_valid), 1);

    // Reset in DONE drops the result immediately
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rdone_valid", 32'(out_valid), 0);
    chk("rdone_sum", 32'(out_sum), 0);
    chk("rdone_count", 32'(out_count), 0);
    chk("rdone_ovf", 32'(out_ovf), 0);
    chk("rdone_ready", 32'(in_ready), 1);
    step();
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
